// File: rtl/seg_pkg.sv
// Shared 7-segment display definitions: scan state encoding, segment constants and glyph table.
package seg_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ON   = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  localparam logic [7:0] SEG_OFF  = 8'hFF;
  localparam logic [7:0] SEG_DASH = 8'hBF;
  localparam logic [2:0] DP_NONE  = 3'd7;

  // Active-high {g,f,e,d,c,b,a}; codes above 9 render as a dash.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    logic [6:0] s;
    case (bcd)
      4'd0:    s = 7'b0111111;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111101;
      4'd7:    s = 7'b0000111;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1101111;
      default: s = 7'b1000000;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg_decoder.sv
// Combinational BCD digit to active-low {dp,g,f,e,d,c,b,a} pattern with blanking.
module seg_decoder
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  input  logic       dp,
  output logic [7:0] seg_c
);

  assign seg_c = blank ? SEG_OFF : {~dp, ~bcd_to_seg(bcd)};

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: shadowed BCD value, per-digit on-time plus blanking gap,
// leading-zero suppression and decimal point.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned DIGITS   = 8,
  parameter int unsigned TICK_DIV = 100000,
  parameter int unsigned GAP_CYC  = 500
)
(
  input  logic                  clk_M,
  input  logic                  rst,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   data_bcd,
  input  logic [2:0]            dp_pos,
  input  logic                  data_valid,
  output logic                  data_ack,
  output logic [7:0]            seg,
  output logic [2:0]            bit_sel,
  output logic                  bit_en,
  output logic                  frame_done
);

  localparam int unsigned DATA_W  = 4 * DIGITS;
  localparam int unsigned CNT_MAX = (TICK_DIV > GAP_CYC) ? TICK_DIV : GAP_CYC;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] TICK_LOAD = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYC - 1);
  localparam logic [2:0]       LAST_SEL  = 3'(DIGITS - 1);

  logic [1:0]        state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [2:0]        sel_d;
  logic              load, fd_d;
  logic [DATA_W-1:0] shadow, shadow_d;
  logic [2:0]        dp_shadow, dp_d;
  logic [3:0]        digit;
  logic              higher_nz, dp_valid, blank, dp_on;
  logic [7:0]        dec_seg, seg_d;
  logic              bit_en_d;

  // State and output registers
  always_ff @(posedge clk_M) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      bit_sel    <= 3'd0;
      bit_en     <= 1'b0;
      seg        <= SEG_OFF;
      data_ack   <= 1'b0;
      frame_done <= 1'b0;
      shadow     <= '0;
      dp_shadow  <= DP_NONE;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      bit_sel    <= sel_d;
      bit_en     <= bit_en_d;
      seg        <= seg_d;
      data_ack   <= load;
      frame_done <= fd_d;
      shadow     <= shadow_d;
      dp_shadow  <= dp_d;
    end
  end

  // Next-state, counter, digit select and shadow-load decision
  always_comb begin
    state_d = state;
    cnt_d   = (cnt != '0) ? cnt - CNT_W'(1) : cnt;
    sel_d   = bit_sel;
    load    = 1'b0;
    fd_d    = 1'b0;
    case (state)
      ST_IDLE: begin
        sel_d = 3'd0;
        load  = data_valid && !data_ack;
        if (en) begin
          state_d = ST_ON;
          cnt_d   = TICK_LOAD;
        end
      end
      ST_ON: begin
        if (cnt == '0) begin
          state_d = ST_GAP;
          cnt_d   = GAP_LOAD;
        end
      end
      ST_GAP: begin
        if (cnt == '0) begin
          if (bit_sel == LAST_SEL) begin
            fd_d = 1'b1;
            load = data_valid && !data_ack;
          end
          if (!en) begin
            state_d = ST_IDLE;
            sel_d   = 3'd0;
          end else begin
            state_d = ST_ON;
            cnt_d   = TICK_LOAD;
            sel_d   = (bit_sel == LAST_SEL) ? 3'd0 : bit_sel + 3'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    shadow_d = load ? data_bcd : shadow;
    dp_d     = load ? dp_pos : dp_shadow;
  end

  // Glyph for the digit about to be driven, taken from the post-load shadow so a new frame
  // never starts with the previous value.
  always_comb begin
    digit     = 4'd0;
    higher_nz = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (3'(i) == sel_d)
        digit = shadow_d[4*i +: 4];
      if (3'(i) > sel_d && shadow_d[4*i +: 4] != 4'd0)
        higher_nz = 1'b1;
    end
    dp_valid = 32'(dp_d) < DIGITS;
    dp_on    = dp_valid && (sel_d == dp_d);
    blank    = (digit == 4'd0) && !higher_nz && (sel_d != 3'd0)
               && !(dp_valid && (sel_d <= dp_d));
  end

  seg_decoder u_dec (
    .bcd   (digit),
    .blank (blank),
    .dp    (dp_on),
    .seg_c (dec_seg)
  );

  assign bit_en_d = (state_d == ST_ON);
  assign seg_d    = bit_en_d ? dec_seg : SEG_OFF;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with a short tick/gap so full frames fit in a few cycles.
module tb_seg_scan_ctrl;

  localparam int unsigned DIGITS   = 4;
  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned GAP_CYC  = 2;

  logic        clk_M = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [15:0] data_bcd = 16'h0;
  logic [2:0]  dp_pos = 3'd7;
  logic        data_valid = 1'b0;
  logic        data_ack;
  logic [7:0]  seg;
  logic [2:0]  bit_sel;
  logic        bit_en;
  logic        frame_done;

  int n_chk  = 0;
  int n_fail = 0;

  seg_scan_ctrl #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV), .GAP_CYC(GAP_CYC)) dut (
    .clk_M      (clk_M),
    .rst        (rst),
    .en         (en),
    .data_bcd   (data_bcd),
    .dp_pos     (dp_pos),
    .data_valid (data_valid),
    .data_ack   (data_ack),
    .seg        (seg),
    .bit_sel    (bit_sel),
    .bit_en     (bit_en),
    .frame_done (frame_done)
  );

  always #5 clk_M = ~clk_M;

  typedef struct packed {
    logic [15:0] bcd;
    logic [2:0]  dp;
    logic [31:0] exp;   // {d3,d2,d1,d0} expected seg patterns
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_M);
    #1;
  endtask

  // Checks one digit's on-time and gap, starting at its first ON sample.
  task automatic check_digit(input int d, input logic [7:0] segv, input logic fd0, input logic ack0);
    for (int k = 0; k < int'(TICK_DIV); k++) begin
      chk($sformatf("seg d%0d on%0d", d, k), 16'(seg), 16'(segv));
      chk($sformatf("bit_en d%0d on%0d", d, k), 16'(bit_en), 16'd1);
      chk($sformatf("bit_sel d%0d on%0d", d, k), 16'(bit_sel), 16'(d));
      chk($sformatf("frame_done d%0d on%0d", d, k), 16'(frame_done), (k == 0) ? 16'(fd0) : 16'd0);
      chk($sformatf("data_ack d%0d on%0d", d, k), 16'(data_ack), (k == 0) ? 16'(ack0) : 16'd0);
      step();
    end
    for (int k = 0; k < int'(GAP_CYC); k++) begin
      chk($sformatf("seg d%0d gap%0d", d, k), 16'(seg), 16'hFF);
      chk($sformatf("bit_en d%0d gap%0d", d, k), 16'(bit_en), 16'd0);
      chk($sformatf("bit_sel d%0d gap%0d", d, k), 16'(bit_sel), 16'(d));
      chk($sformatf("frame_done d%0d gap%0d", d, k), 16'(frame_done), 16'd0);
      step();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " seg"}, 16'(seg), 16'hFF);
    chk({tag, " bit_en"}, 16'(bit_en), 16'd0);
    chk({tag, " bit_sel"}, 16'(bit_sel), 16'd0);
    chk({tag, " data_ack"}, 16'(data_ack), 16'd0);
    chk({tag, " frame_done"}, 16'(frame_done), 16'd0);
  endtask

  initial begin
    logic [31:0] e;

    vecs[0] = '{16'h1234, 3'd7, 32'hF9A4B099};
    vecs[1] = '{16'h0007, 3'd2, 32'hFF40C0F8};
    vecs[2] = '{16'h0056, 3'd7, 32'hFFFF9282};
    vecs[3] = '{16'h0000, 3'd7, 32'hFFFFFFC0};
    vecs[4] = '{16'h00A0, 3'd0, 32'hFFFFBF40};
    vecs[5] = '{16'h9080, 3'd7, 32'h90C080C0};
    vecs[6] = '{16'h0000, 3'd3, 32'h40C0C0C0};
    vecs[7] = '{16'hF000, 3'd5, 32'hBFC0C0C0};
    vecs[8] = '{16'h0300, 3'd1, 32'hFFB040C0};

    // Reset and idle hold
    repeat (3) step();
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (2) step();
    check_reset_outputs("idle hold");

    // One full frame per vector, loaded in IDLE, stopping after the last digit
    for (int v = 0; v < 9; v++) begin
      data_bcd   = vecs[v].bcd;
      dp_pos     = vecs[v].dp;
      data_valid = 1'b1;
      step();
      chk($sformatf("v%0d idle ack", v), 16'(data_ack), 16'd1);
      chk($sformatf("v%0d idle bit_en", v), 16'(bit_en), 16'd0);
      data_valid = 1'b0;
      en = 1'b1;
      step();
      e = vecs[v].exp;
      for (int d = 0; d < int'(DIGITS); d++) begin
        if (d == int'(DIGITS) - 1) en = 1'b0;
        check_digit(d, e[8*d +: 8], 1'b0, 1'b0);
      end
      chk($sformatf("v%0d frame_done", v), 16'(frame_done), 16'd1);
      chk($sformatf("v%0d stop bit_en", v), 16'(bit_en), 16'd0);
      chk($sformatf("v%0d stop seg", v), 16'(seg), 16'hFF);
      step();
      chk($sformatf("v%0d idle frame_done", v), 16'(frame_done), 16'd0);
      chk($sformatf("v%0d idle bit_en", v), 16'(bit_en), 16'd0);
    end

    // Mid-frame update is held off until the frame boundary
    data_bcd   = 16'h1234;
    dp_pos     = 3'd7;
    data_valid = 1'b1;
    step();
    chk("mf idle ack", 16'(data_ack), 16'd1);
    data_valid = 1'b0;
    en = 1'b1;
    step();
    check_digit(0, 8'h99, 1'b0, 1'b0);
    data_bcd   = 16'h0056;
    data_valid = 1'b1;
    check_digit(1, 8'hB0, 1'b0, 1'b0);
    check_digit(2, 8'hA4, 1'b0, 1'b0);
    check_digit(3, 8'hF9, 1'b0, 1'b0);
    data_valid = 1'b0;
    check_digit(0, 8'h82, 1'b1, 1'b1);
    check_digit(1, 8'h92, 1'b0, 1'b0);
    check_digit(2, 8'hFF, 1'b0, 1'b0);
    check_digit(3, 8'hFF, 1'b0, 1'b0);

    // Abort with en=0 during digit 0: finish digit and gap, then idle
    en = 1'b0;
    check_digit(0, 8'h82, 1'b1, 1'b0);
    chk("abort bit_en", 16'(bit_en), 16'd0);
    chk("abort seg", 16'(seg), 16'hFF);
    chk("abort bit_sel", 16'(bit_sel), 16'd0);
    chk("abort frame_done", 16'(frame_done), 16'd0);
    repeat (3) step();
    chk("abort idle bit_en", 16'(bit_en), 16'd0);

    // Synchronous reset mid-digit
    en = 1'b1;
    step();
    check_digit(0, 8'h82, 1'b0, 1'b0);
    chk("pre-rst seg", 16'(seg), 16'h92);
    step();
    rst = 1'b1;
    step();
    check_reset_outputs("mid rst");
    rst = 1'b0;
    en  = 1'b0;
    step();
    check_reset_outputs("post rst idle");
    en = 1'b1;
    step();
    en = 1'b0;
    check_digit(0, 8'hC0, 1'b0, 1'b0);
    chk("cleared shadow stop bit_en", 16'(bit_en), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
